// File: rtl/pipeline_ctrl.sv
// Global stall/flush sequencer for the five-stage RV32I pipeline.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_resp,
  input  logic        mem_req,
  input  logic        dmem_resp,
  input  logic        ex_br_taken,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  output logic        imem_read,
  output logic        dmem_en,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count
);

  typedef enum logic [1:0] {INIT, RUN, WAIT} state_t;

  state_t state_q, state_d;
  logic   i_done_q, i_done_d;
  logic   d_done_q, d_done_d;
  logic   active, i_ok, d_ok, adv, hazard;

  // Sticky flags remember a completed side until the whole pipeline advances.
  assign active = (state_q != INIT);
  assign i_ok   = imem_resp | i_done_q;
  assign d_ok   = ~mem_req | dmem_resp | d_done_q;
  assign adv    = active & i_ok & d_ok;
  assign hazard = ex_is_load & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     state_d = adv ? RUN : WAIT;
      WAIT:    state_d = adv ? RUN : WAIT;
      default: state_d = INIT;
    endcase
    if (adv) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end else if (active) begin
      i_done_d = i_done_q | imem_resp;
      d_done_d = d_done_q | (dmem_resp & mem_req);
    end
  end

  // Branch redirect outranks the load-use hazard: the hazard victim is squashed anyway.
  always_comb begin
    imem_read    = active & ~i_done_q;
    dmem_en      = active & mem_req & ~d_done_q;
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (adv) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (ex_br_taken) begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (hazard) begin
        bubble_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    if (active && !adv) stall_cycles_d = stall_cycles_q + 32'd1;
    if (adv && bubble_id_ex) bubble_count_d = bubble_count_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;
`else
  assign stall_cycles = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  typedef struct {
    logic       imem_resp;
    logic       mem_req;
    logic       dmem_resp;
    logic       ex_br_taken;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_resp = 1'b0, mem_req = 1'b0, dmem_resp = 1'b0;
  logic        ex_br_taken = 1'b0, ex_is_load = 1'b0;
  logic [4:0]  ex_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        imem_read, dmem_en, load_pc, load_if_id, load_id_ex;
  logic        load_ex_mem, load_mem_wb, flush_if_id, bubble_id_ex;
  logic [31:0] stall_cycles, bubble_count;

  int checks = 0;
  int passes = 0;

  // Behavioural model state: started past INIT, outstanding-side memory, counters.
  bit          m_run, m_igot, m_dgot;
  int unsigned m_stall, m_bub;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_resp(imem_resp), .mem_req(mem_req), .dmem_resp(dmem_resp),
    .ex_br_taken(ex_br_taken), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .imem_read(imem_read), .dmem_en(dmem_en),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(logic ir, logic mr, logic dr, logic br, logic ld,
                             logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                             logic u1, logic u2);
    in_t v;
    v.imem_resp = ir; v.mem_req = mr; v.dmem_resp = dr; v.ex_br_taken = br;
    v.ex_is_load = ld; v.ex_rd = rd; v.id_rs1 = r1; v.id_rs2 = r2;
    v.id_use_rs1 = u1; v.id_use_rs2 = u2;
    return v;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {imem_read, dmem_en, load_pc, load_if_id, load_id_ex,
            load_ex_mem, load_mem_wb, flush_if_id, bubble_id_ex};
  endfunction

  // Reference outputs derived from the pipeline rules, ordered like dut_outs().
  function automatic logic [8:0] ref_outs(in_t v);
    bit go, haz;
    if (!m_run) return 9'd0;
    go  = (v.imem_resp || m_igot) && (!v.mem_req || v.dmem_resp || m_dgot);
    haz = v.ex_is_load && v.ex_rd != 0 &&
          ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) || (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
    if (!go)            return {!m_igot, v.mem_req && !m_dgot, 7'b00000_00};
    if (v.ex_br_taken)  return {!m_igot, v.mem_req && !m_dgot, 7'b11111_11};
    if (haz)            return {!m_igot, v.mem_req && !m_dgot, 7'b00111_01};
    return {!m_igot, v.mem_req && !m_dgot, 7'b11111_00};
  endfunction

  function automatic void ref_step(in_t v, logic [8:0] o);
    bit go;
    if (!m_run) begin
      m_run = 1;
      return;
    end
    go = o[4];
    if (go) begin
      m_igot = 0;
      m_dgot = 0;
      if (o[0]) m_bub++;
    end else begin
      m_stall++;
      if (v.imem_resp) m_igot = 1;
      if (v.dmem_resp && v.mem_req) m_dgot = 1;
    end
  endfunction

  task automatic applyStimulus(in_t v);
    imem_resp = v.imem_resp; mem_req = v.mem_req; dmem_resp = v.dmem_resp;
    ex_br_taken = v.ex_br_taken; ex_is_load = v.ex_is_load; ex_rd = v.ex_rd;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
    id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
  endtask

  task automatic checkOutput(string name, logic [8:0] exp);
    logic [8:0] act;
    act = dut_outs();
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b expected %b (imem_read,dmem_en,loads x5,flush,bubble) at %0t",
                  name, act, exp, $time);
  endtask

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic runCycle(string name, in_t v, logic [8:0] exp);
    applyStimulus(v);
    #4;
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it 1 time unit after a posedge.
  task automatic doReset();
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_run = 0; m_igot = 0; m_dgot = 0; m_stall = 0; m_bub = 0;
  endtask

  vec_t tbl[$];
  in_t  idle, ready, v;
  logic [8:0] e;

  initial begin
    idle  = mk(0,0,0,0,0,0,0,0,0,0);
    ready = mk(1,0,0,0,0,0,0,0,0,0);

    // Single-cycle vectors, all from RUN with no outstanding side.
    tbl.push_back('{"normal",        mk(1,0,0,0,0,5'd3,5'd3,5'd3,1,1),  9'b1_0_11111_0_0});
    tbl.push_back('{"hazard_rs2",    mk(1,0,0,0,1,5'd5,5'd1,5'd5,0,1),  9'b1_0_00111_0_1});
    tbl.push_back('{"hazard_rd0",    mk(1,0,0,0,1,5'd0,5'd0,5'd0,1,1),  9'b1_0_11111_0_0});
    tbl.push_back('{"hazard_rs1",    mk(1,0,0,0,1,5'd9,5'd9,5'd2,1,0),  9'b1_0_00111_0_1});
    tbl.push_back('{"unused_match",  mk(1,0,0,0,1,5'd7,5'd7,5'd7,0,0),  9'b1_0_11111_0_0});
    tbl.push_back('{"br_over_haz",   mk(1,0,0,1,1,5'd5,5'd1,5'd5,0,1),  9'b1_0_11111_1_1});
    tbl.push_back('{"branch",        mk(1,0,0,1,0,5'd0,5'd0,5'd0,0,0),  9'b1_0_11111_1_1});
    tbl.push_back('{"mem_same_cyc",  mk(1,1,1,0,0,5'd2,5'd2,5'd4,1,1),  9'b1_1_11111_0_0});
    tbl.push_back('{"not_load_regs", mk(1,0,0,0,0,5'd6,5'd6,5'd6,1,1),  9'b1_0_11111_0_0});
    tbl.push_back('{"imem_wait",     mk(0,0,0,0,0,5'd0,5'd0,5'd0,0,0),  9'b1_0_00000_0_0});
    tbl.push_back('{"stray_dresp",   mk(1,0,1,0,0,5'd0,5'd0,5'd0,0,0),  9'b1_0_11111_0_0});

    // Reset release: cycle 0 INIT, then full advance with imem always ready.
    reset = 1'b0;
    #2;
    checkOutput("in_reset", 9'd0);
    doReset();
    runCycle("init_cycle0", ready, 9'd0);
    for (int i = 1; i <= 3; i++) runCycle($sformatf("run_cycle%0d", i), ready, 9'b1_0_11111_0_0);
    checkValue("reset_stall_cnt", stall_cycles, 32'd0);

    foreach (tbl[i]) runCycle(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Split handshake: imem at cycle 2, dmem at cycle 5.
    doReset();
    runCycle("split_c0", mk(0,1,0,0,0,0,0,0,0,0), 9'd0);
    runCycle("split_c1", mk(0,1,0,0,0,0,0,0,0,0), 9'b1_1_00000_0_0);
    runCycle("split_c2", mk(1,1,0,0,0,0,0,0,0,0), 9'b1_1_00000_0_0);
    runCycle("split_c3", mk(0,1,0,0,0,0,0,0,0,0), 9'b0_1_00000_0_0);
    runCycle("split_c4", mk(0,1,0,0,0,0,0,0,0,0), 9'b0_1_00000_0_0);
    runCycle("split_c5", mk(0,1,1,0,0,0,0,0,0,0), 9'b0_1_11111_0_0);
    runCycle("split_c6", ready, 9'b1_0_11111_0_0);
`ifdef PIPE_CTRL_PERF_EN
    checkValue("split_stall_cnt", stall_cycles, 32'd4);
`else
    checkValue("split_stall_cnt", stall_cycles, 32'd0);
`endif

    // Reset asserted while waiting on dmem with imem already captured.
    doReset();
    runCycle("rwait_c0", idle, 9'd0);
    runCycle("rwait_c1", mk(1,1,0,0,0,0,0,0,0,0), 9'b1_1_00000_0_0);
    applyStimulus(mk(0,1,0,0,0,0,0,0,0,0));
    #2;
    checkOutput("rwait_c2", 9'b0_1_00000_0_0);
    reset = 1'b0;
    #1;
    checkOutput("rwait_async", 9'd0);
    checkValue("rwait_stall_clr", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_run = 0; m_igot = 0; m_dgot = 0; m_stall = 0; m_bub = 0;
    runCycle("rwait_rel_c0", idle, 9'd0);
    runCycle("rwait_rel_c1", idle, 9'b1_0_00000_0_0);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 400; n++) begin
      v.imem_resp   = ($urandom_range(0, 9) < 6);
      v.mem_req     = ($urandom_range(0, 9) < 4);
      v.dmem_resp   = ($urandom_range(0, 9) < 5);
      v.ex_br_taken = ($urandom_range(0, 9) < 2);
      v.ex_is_load  = ($urandom_range(0, 9) < 5);
      v.ex_rd       = 5'($urandom_range(0, 3));
      v.id_rs1      = 5'($urandom_range(0, 3));
      v.id_rs2      = 5'($urandom_range(0, 3));
      v.id_use_rs1  = 1'($urandom);
      v.id_use_rs2  = 1'($urandom);
      e = ref_outs(v);
      runCycle($sformatf("rand_%0d", n), v, e);
      ref_step(v, e);
    end
`ifdef PIPE_CTRL_PERF_EN
    checkValue("rand_stall_cnt", stall_cycles, m_stall);
    checkValue("rand_bubble_cnt", bubble_count, m_bub);
`else
    checkValue("rand_stall_cnt", stall_cycles, 32'd0);
    checkValue("rand_bubble_cnt", bubble_count, 32'd0);
`endif

`ifdef PIPE_CTRL_PERF_EN
    // Bubble counter wraps from all-ones to zero on one hazard bubble.
    applyStimulus(ready);
    dut.bubble_count_q = 32'hFFFF_FFFF;
    #1;
    checkValue("bub_preload", bubble_count, 32'hFFFF_FFFF);
    #3;
    @(posedge clk);
    #1;
    runCycle("wrap_hazard", mk(1,0,0,0,1,5'd5,5'd0,5'd5,0,1), 9'b1_0_00111_0_1);
    checkValue("bub_wrap", bubble_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. Every cycle it decides which stage buffers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB for the instruction, PC and control-word shift registers) load, hold, flush or take a bubble. Inputs are I-/D-memory handshakes, the EX-stage redirect and the load-use hazard. It owns the single global advance decision so no stage register ever shifts out of step with its neighbours.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- imem_resp  in  1  instruction word valid this cycle
- mem_req  in  1  MEM stage holds a load/store (from EX/MEM control word)
- dmem_resp  in  1  data access complete this cycle
- ex_br_taken  in  1  EX stage redirects PC (taken branch/jump)
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID actually reads rs1/rs2
- imem_read  out  1  fetch request
- dmem_en  out  1  data access request
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage load enables
- flush_if_id  out  1  load zero (NOP) into IF/ID instead of fetched word
- bubble_id_ex  out  1  load zero control word into ID/EX
- stall_cycles, bubble_count  out  32 each  performance counters (see Configuration)

## Operation
- States: INIT, RUN, WAIT. Two sticky flags: i_done, d_done.
- INIT: entered on reset; all outputs 0; unconditionally to RUN next cycle.
- i_ok = imem_resp | i_done; d_ok = ~mem_req | dmem_resp | d_done; adv = (state != INIT) & i_ok & d_ok.
- imem_read = (state != INIT) & ~i_done; dmem_en = (state != INIT) & mem_req & ~d_done.
- Flags: on adv both clear; else i_done sets on imem_resp, d_done sets on dmem_resp & mem_req. dmem_resp without mem_req ignored.
- RUN -> WAIT when ~adv; WAIT -> RUN on adv (WAIT == at least one side outstanding).
- hazard = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- On ~adv: every load_* = 0, flush/bubble = 0.
- On adv, priority order:
  - ex_br_taken: all load_* = 1, flush_if_id = 1, bubble_id_ex = 1 (two wrong-path instructions squashed; hazard ignored).
  - hazard: load_pc = load_if_id = 0; load_id_ex = load_ex_mem = load_mem_wb = 1; bubble_id_ex = 1.
  - otherwise: all load_* = 1, flush/bubble = 0.
- ex_br_taken and hazard inputs are sampled only on the adv cycle; upstream holds them stable while stalled.

## Timing
- Load/flush/bubble outputs and request outputs are combinational (Mealy) from state, flags and current inputs; zero-cycle latency from handshake to advance.
- Reset (reset = 0, asynchronous): state = INIT, i_done = d_done = 0, counters = 0; all outputs 0 throughout reset and the first cycle after release.
- Reset mid-stall: outstanding flags discarded; requests reissue from RUN.
- imem_resp and dmem_resp in the same cycle: advance that cycle.
- Response on one side while the other waits: flag holds it; request for that side drops next cycle and is not reissued until after adv.
- Back-to-back hazard cannot repeat: the bubble in EX is not a load.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles increments each non-INIT cycle with ~adv; bubble_count increments each adv cycle with bubble_id_ex = 1; both 32-bit, wrap 0xFFFFFFFF -> 0, cleared only by reset.
- Not defined: counter logic omitted, both ports driven constant 0.

## Test plan
- Reset release, imem_resp held 1, mem_req 0: cycle 0 all outputs 0 (INIT); from cycle 1 all load_* = 1 each cycle, imem_read = 1.
- mem_req = 1, imem_resp at cycle 2, dmem_resp at cycle 5: no load_* asserted cycles 1-4, imem_read drops at cycle 3, single adv at cycle 5; stall_cycles = 4 with PERF_EN.
- ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1, memories ready: load_pc = load_if_id = 0, bubble_id_ex = 1, other loads 1; same with ex_rd = 0: normal advance.
- ex_br_taken = 1 together with the hazard above: all loads 1, flush_if_id = 1, bubble_id_ex = 1.
- Assert reset during WAIT with i_done = 1: outputs 0 immediately; after release imem_read reasserts at cycle 1.
- PERF_EN, preload bubble_count to 0xFFFFFFFF via 2^32 forced state or backdoor, one hazard: wraps to 0.
